// File: rtl/shreg_pkg.sv
// Shared types and constants for the tapped shift register and its write-side controller.
package shreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int SHREG_DW    = 8;
  localparam int SHREG_DEPTH = 6;

  function automatic logic [2:0] sat_inc3(input logic [2:0] val, input logic [2:0] lim);
    return (val == lim) ? val : val + 3'd1;
  endfunction

endpackage

// File: rtl/shreg_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last served requester.
module rr_arb2
  import shreg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_r;

  // Grant selection: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_r == SRC_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Last-served pointer; resetting to B makes A the first winner of a tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= SRC_B;
    end else if (accept) begin
      last_r <= gnt[1];
    end
  end

endmodule

// File: rtl/shreg_ctrl.sv
// Write-side controller for the tapped shift register: two-source round-robin feed,
// fill tracking and a zero-fill flush. Optional per-source counters via SHREG_CTRL_STATS_EN.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter int DW    = SHREG_DW,
  parameter int DEPTH = SHREG_DEPTH,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  input  logic            flush,
  output logic            busy,
  output logic [DW-1:0]   sr_data,
  output logic            sr_shren,
  output logic [2:0]      fill_cnt,
  output logic            window_full,
  output logic            last_src
`ifdef SHREG_CTRL_STATS_EN
  ,
  output logic [CNTW-1:0] a_cnt,
  output logic [CNTW-1:0] b_cnt
`endif
);

  localparam logic [2:0] DEPTH3 = 3'(DEPTH);

  state_t        state_r, state_nxt_s;
  logic [2:0]    flush_cnt_r, flush_cnt_nxt_s;
  logic [1:0]    gnt_s;
  logic          arb_en_s, accept_s;
  logic [DW-1:0] sr_data_r, data_nxt_s;
  logic          sr_shren_r, shren_nxt_s;
  logic          is_data_r, is_data_nxt_s;
  logic [2:0]    fill_cnt_r, fill_nxt_s;
  logic          window_full_r;
  logic          last_src_r, last_nxt_s;

  assign arb_en_s = !rst && (state_r == IDLE) && !flush;
  assign accept_s = gnt_s[0] | gnt_s[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_valid, a_valid}),
    .en     (arb_en_s),
    .accept (accept_s),
    .gnt    (gnt_s)
  );

  // Next-state and next-output logic; flush entry clears the fill count over any in-flight shift
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    shren_nxt_s     = 1'b0;
    data_nxt_s      = '0;
    is_data_nxt_s   = 1'b0;
    last_nxt_s      = last_src_r;
    if (sr_shren_r && is_data_r) begin
      fill_nxt_s = sat_inc3(fill_cnt_r, DEPTH3);
    end else begin
      fill_nxt_s = fill_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s     = FLUSH;
          flush_cnt_nxt_s = 3'd0;
          shren_nxt_s     = 1'b1;
          fill_nxt_s      = 3'd0;
        end else if (accept_s) begin
          shren_nxt_s   = 1'b1;
          data_nxt_s    = gnt_s[1] ? b_data : a_data;
          is_data_nxt_s = 1'b1;
          last_nxt_s    = gnt_s[1];
        end else begin
          shren_nxt_s = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == DEPTH3 - 3'd1) begin
          state_nxt_s     = IDLE;
          flush_cnt_nxt_s = 3'd0;
          shren_nxt_s     = 1'b0;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + 3'd1;
          shren_nxt_s     = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        flush_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      flush_cnt_r   <= 3'd0;
      sr_data_r     <= '0;
      sr_shren_r    <= 1'b0;
      is_data_r     <= 1'b0;
      fill_cnt_r    <= 3'd0;
      window_full_r <= 1'b0;
      last_src_r    <= SRC_A;
    end else begin
      state_r       <= state_nxt_s;
      flush_cnt_r   <= flush_cnt_nxt_s;
      sr_data_r     <= data_nxt_s;
      sr_shren_r    <= shren_nxt_s;
      is_data_r     <= is_data_nxt_s;
      fill_cnt_r    <= fill_nxt_s;
      window_full_r <= (fill_nxt_s == DEPTH3);
      last_src_r    <= last_nxt_s;
    end
  end

`ifdef SHREG_CTRL_STATS_EN
  logic [CNTW-1:0] a_cnt_r, b_cnt_r;

  // Per-source accept counters; wrap freely and survive a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_r <= '0;
      b_cnt_r <= '0;
    end else begin
      if (gnt_s[0]) a_cnt_r <= a_cnt_r + CNTW'(1);
      if (gnt_s[1]) b_cnt_r <= b_cnt_r + CNTW'(1);
    end
  end

  assign a_cnt = a_cnt_r;
  assign b_cnt = b_cnt_r;
`endif

  assign a_ready     = gnt_s[0];
  assign b_ready     = gnt_s[1];
  assign busy        = (state_r == FLUSH);
  assign sr_data     = sr_data_r;
  assign sr_shren    = sr_shren_r;
  assign fill_cnt    = fill_cnt_r;
  assign window_full = window_full_r;
  assign last_src    = last_src_r;

endmodule

// File: tb/tb_shreg_ctrl.sv
// Self-checking bench for shreg_ctrl: directed scenarios plus random traffic against a
// transaction-level model (queue-free counters of fill, flush cycles left and RR preference).
module tb_shreg_ctrl;
  import shreg_pkg::*;

  localparam int DW = 8, DEPTH = 6, CNTW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, flush = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, busy, sr_shren, window_full, last_src;
  logic [DW-1:0] sr_data;
  logic [2:0] fill_cnt;
`ifdef SHREG_CTRL_STATS_EN
  logic [CNTW-1:0] a_cnt, b_cnt;
`endif

  shreg_ctrl #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .flush(flush), .busy(busy),
    .sr_data(sr_data), .sr_shren(sr_shren),
    .fill_cnt(fill_cnt), .window_full(window_full), .last_src(last_src)
`ifdef SHREG_CTRL_STATS_EN
    , .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;

  // model state
  int       m_fill, m_flush_left, m_acnt, m_bcnt;
  bit       m_shren, m_is_data, m_last, m_prefer_b;
  bit [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_flush_left = 0; m_acnt = 0; m_bcnt = 0;
    m_shren = 0; m_is_data = 0; m_last = 0; m_prefer_b = 0; m_data = 8'h00;
  endtask

  // One clock of stimulus: check readies and registered outputs, then advance the model
  task automatic step(input bit av, input bit [7:0] ad, input bit bv, input bit [7:0] bd,
                      input bit fl, input bit r);
    bit ea, eb, busy_e;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; flush = fl; rst = r;
    #1;
    busy_e = (m_flush_left > 0);
    ea = 1'b0; eb = 1'b0;
    if (!r && !busy_e && !fl) begin
      if (av && bv) begin
        ea = !m_prefer_b; eb = m_prefer_b;
      end else begin
        ea = av; eb = bv;
      end
    end
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("sr_shren", 32'(sr_shren), 32'(m_shren));
    if (m_shren) chk("sr_data", 32'(sr_data), 32'(m_data));
    chk("fill_cnt", 32'(fill_cnt), 32'(m_fill));
    chk("window_full", 32'(window_full), 32'(m_fill == DEPTH));
    chk("last_src", 32'(last_src), 32'(m_last));
`ifdef SHREG_CTRL_STATS_EN
    chk("a_cnt", 32'(a_cnt), 32'(m_acnt % 65536));
    chk("b_cnt", 32'(b_cnt), 32'(m_bcnt % 65536));
`endif
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (m_shren && m_is_data && m_fill < DEPTH) m_fill++;
      if (busy_e) begin
        m_flush_left--;
        m_shren = (m_flush_left > 0); m_data = 8'h00; m_is_data = 0;
      end else if (fl) begin
        m_flush_left = DEPTH; m_fill = 0;
        m_shren = 1; m_data = 8'h00; m_is_data = 0;
      end else if (ea || eb) begin
        m_shren = 1; m_is_data = 1; m_data = eb ? bd : ad;
        m_last = eb; m_prefer_b = !eb;
        if (eb) m_bcnt++; else m_acnt++;
      end else begin
        m_shren = 0; m_is_data = 0;
      end
    end
  endtask

  initial begin
    int na, nb, busy_len;
    bit [7:0] seq [4];
    bit [7:0] exp_seq [4];
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'hB0; exp_seq[2] = 8'hA1; exp_seq[3] = 8'hB1;

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step(1, 8'h55, 1, 8'h66, 0, 1);

    // single A sample
    step(1, 8'h11, 0, 8'h00, 0, 0);
    chk("tp1_shren", 32'(sr_shren), 32'd1);
    chk("tp1_data", 32'(sr_data), 32'h11);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    chk("tp1_fill", 32'(fill_cnt), 32'd1);
    chk("tp1_last", 32'(last_src), 32'd0);

    // alternating grants with both sources valid
    step(0, 8'h00, 0, 8'h00, 0, 1);
    na = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'hA0 + na), 1, 8'(8'hB0 + nb), 0, 0);
      seq[i] = sr_data;
      if (last_src) nb++; else na++;
    end
    for (int i = 0; i < 4; i++) chk("tp2_seq", 32'(seq[i]), 32'(exp_seq[i]));

    // saturation with back-to-back A
    step(0, 8'h00, 0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    chk("tp3_fill", 32'(fill_cnt), 32'd6);
    chk("tp3_full", 32'(window_full), 32'd1);

    // flush beats a simultaneous request
    step(1, 8'h77, 0, 8'h00, 1, 0);
    chk("tp4_fill", 32'(fill_cnt), 32'd0);
    busy_len = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_len++;
      step(1, 8'h77, 0, 8'h00, 0, 0);
    end
    chk("tp4_busy_len", 32'(busy_len), 32'd6);

    // reset in the third flush cycle
    step(0, 8'h00, 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 0, 0);
    chk("tp5_busy_before", 32'(busy), 32'd1);
    step(0, 8'h00, 0, 8'h00, 0, 1);
    chk("tp5_busy", 32'(busy), 32'd0);
    chk("tp5_shren", 32'(sr_shren), 32'd0);
    step(1, 8'h31, 1, 8'h41, 0, 0);
    chk("tp5_a_first", 32'(last_src), 32'd0);

`ifdef SHREG_CTRL_STATS_EN
    // counters survive a flush, cleared by reset
    step(0, 8'h00, 0, 8'h00, 0, 1);
    for (int i = 0; i < 2; i++) step(1, 8'h01, 1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 0, 8'h00, 0, 0);
    chk("tp6_a_cnt", 32'(a_cnt), 32'd3);
    chk("tp6_b_cnt", 32'(b_cnt), 32'd2);
    step(0, 8'h00, 0, 8'h00, 0, 1);
    chk("tp6_a_clr", 32'(a_cnt), 32'd0);
    chk("tp6_b_clr", 32'(b_cnt), 32'd0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), 8'($urandom),
           bit'($urandom_range(0, 2) != 0), 8'($urandom),
           bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
